// File: rtl/instruction_encoder_if.sv
// Field-bundle handshake between the host/boot side and the instruction encoder.
// One instruction is presented as separated fields; in_ready is the encoder's back-pressure.
interface instruction_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_fmt;
    logic [5:0]  in_opcode;
    logic [5:0]  in_funct;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [4:0]  in_shamt;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        in_last;

    modport master (
        output in_valid, in_fmt, in_opcode, in_funct, in_rs, in_rt, in_rd,
               in_shamt, in_imm, in_target, in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_fmt, in_opcode, in_funct, in_rs, in_rt, in_rd,
               in_shamt, in_imm, in_target, in_last,
        output in_ready
    );
endinterface

// File: rtl/instruction_encoder.sv
// Mini-MIPS instruction encoder: checks field bundles against the decoded ISA,
// packs legal ones into 32-bit words and streams them into instruction memory.
module instruction_encoder #(
    parameter int ADDR_WIDTH = 8,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    instruction_encoder_if.slave  bus,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  busy,
    output logic                  full,
    output logic                  done,
    output logic                  err,
    output logic [7:0]            err_count,
    output logic [ADDR_WIDTH:0]   words_written
);

    localparam logic [ADDR_WIDTH-1:0] BASE  = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] ONE_A = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   ONE_W = (ADDR_WIDTH+1)'(1);

    typedef enum logic [1:0] {IDLE, LOAD, FULL, DONE} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic                  legal;
    logic [31:0]           word;
    logic [4:0]            sh;
    logic [4:0]            rt_r;
    logic [4:0]            rd_r;
    logic [4:0]            rs_i;

    assign bus.in_ready = (state == LOAD);
    assign busy         = (state == LOAD);
    assign full         = (state == FULL);
    assign done         = (state == DONE);

    function automatic logic r_legal(input logic [5:0] f);
        case (f)
            6'h20, 6'h21, 6'h22, 6'h23, 6'h18, 6'h24, 6'h25, 6'h26,
            6'h27, 6'h00, 6'h02, 6'h03, 6'h2a, 6'h08, 6'h10, 6'h12: r_legal = 1'b1;
            default: r_legal = 1'b0;
        endcase
    endfunction

    function automatic logic i_legal(input logic [5:0] op);
        case (op)
            6'h08, 6'h09, 6'h0c, 6'h0d, 6'h0e, 6'h23, 6'h2b, 6'h0f,
            6'h04, 6'h05, 6'h07, 6'h01, 6'h16, 6'h17, 6'h0a, 6'h18: i_legal = 1'b1;
            default: i_legal = 1'b0;
        endcase
    endfunction

    // Fields a format does not use are masked so stale host values never leak into the word.
    always_comb begin
        legal = 1'b0;
        word  = 32'h0;
        sh    = (bus.in_funct == 6'h00 || bus.in_funct == 6'h02 || bus.in_funct == 6'h03)
                ? bus.in_shamt : 5'd0;
        rt_r  = (bus.in_funct == 6'h08) ? 5'd0 : bus.in_rt;
        rd_r  = (bus.in_funct == 6'h08) ? 5'd0 : bus.in_rd;
        rs_i  = (bus.in_opcode == 6'h0f) ? 5'd0 : bus.in_rs;
        case (bus.in_fmt)
            2'd0: begin
                legal = r_legal(bus.in_funct);
                word  = {6'h00, bus.in_rs, rt_r, rd_r, sh, bus.in_funct};
            end
            2'd1: begin
                legal = i_legal(bus.in_opcode);
                word  = {bus.in_opcode, rs_i, bus.in_rt, bus.in_imm};
            end
            2'd2: begin
                legal = (bus.in_opcode == 6'h02) || (bus.in_opcode == 6'h03);
                word  = {bus.in_opcode, bus.in_target};
            end
            default: begin
                legal = (bus.in_funct == 6'h00) || (bus.in_funct == 6'h01);
                word  = {6'h1c, bus.in_rs, bus.in_rt, 10'b0, bus.in_funct};
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            imem_we       <= 1'b0;
            imem_addr     <= '0;
            imem_wdata    <= 32'h0;
            err           <= 1'b0;
            err_count     <= 8'h0;
            words_written <= '0;
        end else begin
            imem_we <= 1'b0;
            if (start) begin
                // start outranks a same-cycle field bundle in every state
                state         <= LOAD;
                wr_ptr        <= BASE;
                words_written <= '0;
                err           <= 1'b0;
                err_count     <= 8'h0;
            end else begin
                case (state)
                    LOAD: begin
                        if (bus.in_valid) begin
                            if (legal) begin
                                imem_we       <= 1'b1;
                                imem_addr     <= wr_ptr;
                                imem_wdata    <= word;
                                wr_ptr        <= wr_ptr + ONE_A;
                                words_written <= words_written + ONE_W;
                            end else begin
                                err <= 1'b1;
                                if (err_count != 8'hff)
                                    err_count <= err_count + 8'd1;
                            end
                            if (bus.in_last)
                                state <= DONE;
                            else if (legal && (&wr_ptr))
                                state <= FULL;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= state;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instruction_encoder.sv
// Self-checking bench for instruction_encoder: cycle model of the load session,
// per-cycle output comparison, and literal word/address expectations.
module tb_instruction_encoder;
    localparam int AW    = 2;
    localparam int BASE  = 0;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          busy, full, done, err;
    logic [7:0]    err_count;
    logic [AW:0]   words_written;

    instruction_encoder_if bus();

    instruction_encoder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .full(full), .done(done), .err(err),
        .err_count(err_count), .words_written(words_written)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int r_ok[16] = '{'h20, 'h21, 'h22, 'h23, 'h18, 'h24, 'h25, 'h26,
                     'h27, 'h00, 'h02, 'h03, 'h2a, 'h08, 'h10, 'h12};
    int i_ok[16] = '{'h08, 'h09, 'h0c, 'h0d, 'h0e, 'h23, 'h2b, 'h0f,
                     'h04, 'h05, 'h07, 'h01, 'h16, 'h17, 'h0a, 'h18};

    function automatic bit in_set(input int v, input int s[16]);
        foreach (s[k]) if (s[k] == v) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_legal(input int fmt, input int op, input int f);
        case (fmt)
            0: return in_set(f, r_ok);
            1: return in_set(op, i_ok);
            2: return (op == 2) || (op == 3);
            default: return (f == 0) || (f == 1);
        endcase
    endfunction

    function automatic int unsigned m_enc(input int fmt, input int op, input int f,
                                          input int rs, input int rt, input int rd,
                                          input int sh, input int imm, input int tgt);
        int unsigned p26 = 32'd67108864, p21 = 32'd2097152, p16 = 32'd65536, p11 = 32'd2048;
        case (fmt)
            0: begin
                if (!(f == 0 || f == 2 || f == 3)) sh = 0;
                if (f == 8) begin rt = 0; rd = 0; end
                return rs * p21 + rt * p16 + rd * p11 + sh * 64 + f;
            end
            1: return op * p26 + ((op == 'h0f) ? 0 : rs) * p21 + rt * p16 + imm;
            2: return op * p26 + tgt;
            default: return 32'h1c * p26 + rs * p21 + rt * p16 + f;
        endcase
    endfunction

    typedef enum {M_IDLE, M_LOAD, M_FULL, M_DONE} mode_t;
    mode_t       mode = M_IDLE;
    int          m_ptr = 0, m_ww = 0, m_errc = 0;
    bit          m_err = 0, m_we = 0;
    int          m_addr = 0;
    int unsigned m_data = 0;
    bit          m_legal_now;

    always @(posedge clk) begin
        if (!rst_n) begin
            mode = M_IDLE; m_ptr = 0; m_ww = 0; m_errc = 0; m_err = 0;
            m_we = 0; m_addr = 0; m_data = 0;
        end else begin
            m_we = 0;
            if (start) begin
                mode = M_LOAD; m_ptr = BASE; m_ww = 0; m_err = 0; m_errc = 0;
            end else if (mode == M_DONE) begin
                mode = M_IDLE;
            end else if (mode == M_LOAD && bus.in_valid) begin
                m_legal_now = m_legal(bus.in_fmt, bus.in_opcode, bus.in_funct);
                if (m_legal_now) begin
                    m_we = 1; m_addr = m_ptr;
                    m_data = m_enc(bus.in_fmt, bus.in_opcode, bus.in_funct, bus.in_rs, bus.in_rt,
                                   bus.in_rd, bus.in_shamt, bus.in_imm, bus.in_target);
                    m_ww = m_ww + 1;
                end else begin
                    m_err = 1;
                    m_errc = (m_errc < 255) ? m_errc + 1 : 255;
                end
                if (bus.in_last) mode = M_DONE;
                else if (m_legal_now && m_ptr == DEPTH - 1) mode = M_FULL;
                if (m_legal_now) m_ptr = (m_ptr + 1) % DEPTH;
            end
        end
    end

    // ---------------- per-cycle compare + write log ----------------
    bit          chk_en = 0;
    int          log_a[$];
    int unsigned log_d[$];

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", bus.in_ready, mode == M_LOAD);
            chk("busy", busy, mode == M_LOAD);
            chk("full", full, mode == M_FULL);
            chk("done", done, mode == M_DONE);
            chk("imem_we", imem_we, m_we);
            chk("imem_addr", imem_addr, m_addr);
            chk("imem_wdata", imem_wdata, m_data);
            chk("err", err, m_err);
            chk("err_count", err_count, m_errc);
            chk("words_written", words_written, m_ww);
        end
        if (imem_we === 1'b1) begin
            log_a.push_back(int'(imem_addr));
            log_d.push_back(imem_wdata);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(); start = 1'b0;
        log_a.delete(); log_d.delete();
    endtask

    task automatic drive(input int fmt, input int op, input int f, input int rs, input int rt,
                         input int rd, input int sh, input int imm, input int tgt, input bit last);
        bus.in_valid = 1'b1; bus.in_fmt = 2'(fmt); bus.in_opcode = 6'(op); bus.in_funct = 6'(f);
        bus.in_rs = 5'(rs); bus.in_rt = 5'(rt); bus.in_rd = 5'(rd); bus.in_shamt = 5'(sh);
        bus.in_imm = 16'(imm); bus.in_target = 26'(tgt); bus.in_last = last;
        cyc();
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        repeat (n) cyc();
    endtask

    initial begin
        bus.in_valid = 0; bus.in_fmt = 0; bus.in_opcode = 0; bus.in_funct = 0;
        bus.in_rs = 0; bus.in_rt = 0; bus.in_rd = 0; bus.in_shamt = 0;
        bus.in_imm = 0; bus.in_target = 0; bus.in_last = 0;
        repeat (2) cyc();
        chk_en = 1;
        cyc();
        rst_n = 1'b1;
        cyc();

        // model pinned against hand-packed words
        chk("enc_add", m_enc(0, 0, 'h20, 1, 2, 3, 5, 0, 0), 32'h00221820);
        chk("enc_addi", m_enc(1, 'h08, 0, 1, 2, 0, 0, 5, 0), 32'h20220005);
        chk("enc_jr", m_enc(0, 0, 'h08, 31, 5, 6, 0, 0, 0), 32'h03e00008);
        chk("enc_lui", m_enc(1, 'h0f, 0, 7, 3, 0, 0, 'h1234, 0), 32'h3c031234);

        // basic two-instruction session; shamt garbage on add must be dropped
        pulse_start();
        drive(0, 0, 'h20, 1, 2, 3, 5, 0, 0, 0);
        drive(1, 'h08, 0, 1, 2, 9, 0, 'h0005, 0, 1);
        idle(3);
        chk("t1_n", log_a.size(), 2);
        chk("t1_a0", log_a[0], 0); chk("t1_d0", log_d[0], 32'h00221820);
        chk("t1_a1", log_a[1], 1); chk("t1_d1", log_d[1], 32'h20220005);
        chk("t1_ww", words_written, 2);
        chk("t1_idle", busy, 0);

        // back-to-back fills the 4-word memory, then FULL holds a fifth bundle
        pulse_start();
        drive(2, 'h02, 0, 0, 0, 0, 0, 0, 'h10, 0);
        drive(3, 0, 'h00, 4, 5, 7, 3, 0, 0, 0);
        drive(0, 0, 'h00, 0, 2, 2, 4, 0, 0, 0);
        drive(1, 'h23, 0, 29, 8, 0, 0, 'hfffc, 0, 0);
        drive(1, 'h08, 0, 1, 1, 0, 0, 1, 0, 0);
        repeat (3) cyc();
        chk("t2_n", log_a.size(), 4);
        chk("t2_d0", log_d[0], 32'h08000010); chk("t2_d1", log_d[1], 32'h70850000);
        chk("t2_d2", log_d[2], 32'h00021100); chk("t2_d3", log_d[3], 32'h8fa8fffc);
        chk("t2_a3", log_a[3], 3);
        chk("t2_full", full, 1); chk("t2_rdy", bus.in_ready, 0);
        start = 1'b1; cyc(); start = 1'b0;
        idle(1);
        chk("t2_restart_ww", words_written, 0); chk("t2_restart_busy", busy, 1);

        // illegal funct, then or / jr / lui (rs forced to 0)
        pulse_start();
        drive(0, 0, 'h3f, 1, 2, 3, 0, 0, 0, 0);
        drive(0, 0, 'h25, 1, 2, 3, 0, 0, 0, 0);
        drive(0, 0, 'h08, 31, 5, 6, 0, 0, 0, 0);
        drive(1, 'h0f, 0, 7, 3, 0, 0, 'h1234, 0, 1);
        idle(2);
        chk("t3_n", log_a.size(), 3);
        chk("t3_a0", log_a[0], BASE); chk("t3_d0", log_d[0], 32'h00221825);
        chk("t3_d1", log_d[1], 32'h03e00008); chk("t3_d2", log_d[2], 32'h3c031234);
        chk("t3_err", err, 1); chk("t3_errc", err_count, 1);

        // start with in_valid in LOAD: no write; then reset mid-session drops a write
        pulse_start();
        drive(0, 0, 'h21, 1, 1, 1, 0, 0, 0, 0);
        start = 1'b1;
        drive(0, 0, 'h21, 2, 2, 2, 0, 0, 0, 0);
        start = 1'b0;
        idle(1);
        chk("t4_ww", words_written, 0);
        chk("t4_n", log_a.size(), 1);
        drive(0, 0, 'h22, 3, 3, 3, 0, 0, 0, 0);
        chk("t4_a_after", imem_addr, BASE);
        rst_n = 1'b0;
        drive(0, 0, 'h22, 4, 4, 4, 0, 0, 0, 0);
        rst_n = 1'b1;
        idle(1);
        chk("t4_rst_we", imem_we, 0); chk("t4_rst_addr", imem_addr, 0);
        chk("t4_rst_data", imem_wdata, 0); chk("t4_rst_busy", busy, 0);
        chk("t4_rst_ww", words_written, 0); chk("t4_rst_errc", err_count, 0);

        // last at the final address ends in DONE, not FULL
        pulse_start();
        for (int i = 0; i < 3; i++) drive(0, 0, 'h2a, i, i + 1, i + 2, 0, 0, 0, 0);
        drive(2, 'h03, 0, 0, 0, 0, 0, 0, 'h3ffffff, 1);
        chk("t5_done", done, 1); chk("t5_full", full, 0);
        idle(2);
        chk("t5_ww", words_written, 4); chk("t5_d3", log_d[3], 32'h0fffffff);

        // err_count saturation
        pulse_start();
        for (int i = 0; i < 300; i++) drive(2, 'h3f, 0, 0, 0, 0, 0, 0, i, 0);
        idle(2);
        chk("t6_errc", err_count, 255); chk("t6_n", log_a.size(), 0);
        chk("t6_ww", words_written, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instruction_encoder.md
# instruction_encoder

Field-level instruction encoder and instruction-memory loader for the Mini-MIPS core, the write-side counterpart of the instruction decoder. It accepts one instruction per cycle as separated fields over a valid/ready handshake, checks the opcode/funct combination against the ISA the core decodes, and packs legal instructions into 32-bit words. It then writes them to consecutive instruction-memory addresses. It sits between the host/boot interface and the instruction memory write port.

## Interface
- ADDR_WIDTH, 8, instruction-memory word-address width (depth 2^ADDR_WIDTH).
- BASE_ADDR, 0, first word address written after `start`.
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- start  in  1  begins or restarts a load session.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept this cycle.
- in_fmt  in  2  0=R, 1=I, 2=J, 3=SPECIAL2 (madd/maddu).
- in_opcode  in  6  opcode; used for I and J only.
- in_funct  in  6  funct; used for R and SPECIAL2.
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register/shift fields.
- in_imm  in  16  immediate/branch offset.
- in_target  in  26  jump target.
- in_last  in  1  marks final instruction of session.
- imem_we  out  1  instruction-memory write enable.
- imem_addr  out  ADDR_WIDTH  write address.
- imem_wdata  out  32  encoded word.
- busy  out  1  state is LOAD.
- full  out  1  state is FULL.
- done  out  1  one-cycle end-of-session pulse.
- err  out  1  sticky illegal-instruction flag, cleared by `start`.
- err_count  out  8  illegal instructions this session, saturates at 255.
- words_written  out  ADDR_WIDTH+1  legal words written this session.

## Operation
- States: IDLE, LOAD, FULL, DONE. Reset → IDLE.
- IDLE: in_ready=0. start → LOAD; wr_ptr←BASE_ADDR, words_written←0, err←0, err_count←0.
- LOAD: in_ready=1. An accept occurs when in_valid && in_ready.
- FULL: in_ready=0, full=1. Only start exits (→ LOAD, same init as IDLE).
- DONE: done=1 for exactly one cycle, in_ready=0 → IDLE.
- start in LOAD/FULL/DONE: aborts and restarts; same-cycle in_valid is ignored (start has priority).
- Legality:
  - R: funct ∈ {20,21,22,23,18,24,25,26,27,00,02,03,2a,08,10,12}.
  - I: opcode ∈ {08,09,0c,0d,0e,23,2b,0f,04,05,07,01,16,17,0a,18}.
  - J: opcode ∈ {02,03}.
  - SPECIAL2: funct ∈ {00,01}.
- Packing:
  - R: {6'h00, rs, rt, rd, sh, funct}. sh=in_shamt for funct ∈ {00,02,03}, else 0. For funct 08 (jr), rt and rd are forced to 0.
  - I: {opcode, rs, rt, imm}. rs is forced to 0 for opcode 0f (lui).
  - J: {opcode, target}.
  - SPECIAL2: {6'h1c, rs, rt, 10'b0, funct}.
- Legal accept:
  - Word written to wr_ptr.
  - wr_ptr and words_written increment.
- Illegal accept:
  - No write, wr_ptr unchanged.
  - err←1, err_count increments and saturates.
- State after accept:
  - in_last → DONE (legal or illegal).
  - Else legal word written at wr_ptr = all-ones → FULL, and wr_ptr wraps to 0 but is unused.
  - Else stay in LOAD.
  - in_last at the last address → DONE, not FULL.
- Non-accept cycles in LOAD change nothing.

## Timing
- Write is registered: an accept in cycle N gives imem_we=1 with addr/wdata in cycle N+1. Latency is 1 cycle.
- Throughput is one instruction per cycle; back-to-back accepts produce consecutive writes.
- imem_we is high only the cycle after a legal accept. imem_addr and imem_wdata hold their values otherwise.
- err, err_count, words_written update in cycle N+1.
- The final write's cycle equals the done cycle; done is not delayed further.
- busy, full, in_ready are decoded from the current state (Moore).
- Reset values: state IDLE, in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, busy 0, full 0, done 0, err 0, err_count 0, words_written 0.
- Reset asserted mid-session: next edge reaches IDLE and a pending write is dropped (imem_we=0).

## Test plan
- Start; accept R add rs=1,rt=2,rd=3 (funct 20), then last I addi rs=1,rt=2,imm=0x0005 → writes 0x00221820@0, 0x20220005@1; done pulses with second write; words_written=2; IDLE.
- Back-to-back: J target 0x0000010, SPECIAL2 madd rs=4,rt=5, R sll rt=2,rd=2,sh=4, lw rt=8,rs=29,imm=0xfffc, each on consecutive cycles → four consecutive writes 0x08000010, 0x70850000, 0x00021100, 0x8fa8fffc; no bubbles.
- Illegal: R funct 0x3f, then legal or 0x00221825 → err=1, err_count=1, only one write, at BASE_ADDR; lui rs=7 packs with rs=0.
- Fill: ADDR_WIDTH=2, five legal non-last instructions → writes to 0..3, then FULL with in_ready=0; fifth held; start → LOAD, words_written=0.
- start asserted with in_valid in LOAD → no write, wr_ptr=BASE_ADDR; rst_n low for one cycle mid-session → all outputs at reset values.
- Saturation: 300 illegal accepts → err_count=255, no writes.
